// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// WIDTH-bit operands are split into BLOCK-bit slices. Each pipeline stage
// resolves one slice with a generate/propagate lookahead chain, so the
// critical path is a single BLOCK-bit carry chain.
// Stage k forwards three things to stage k+1:
//   - the completed low sum bits,
//   - the operand bits not yet consumed (the operand registers shrink as
//     slices are resolved),
//   - the slice carry-out.
// The last stage also registers the carry into the MSB so that signed
// overflow can be formed, plus the zero flag.
// The whole pipeline holds on backpressure, bubbles included, so a stalled
// result stays stable at the outputs.
// WIDTH must be a non-zero multiple of BLOCK.
module cla_pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             carry_in,
    input  logic             sub_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int STAGES = WIDTH / BLOCK;

    // Pipeline advance: every stage moves together or holds together.
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Operand prep: subtraction is A + ~B + ~borrow. With carry_in = 0,
    // sub yields A - B.
    logic [WIDTH-1:0] b_prep;
    logic             cin_prep;
    assign b_prep   = sub_flag ? ~src2 : src2;
    assign cin_prep = sub_flag ^ carry_in;

    // Valid shift register, one bit per stage; bubbles are held like data.
    logic [STAGES-1:0] vld_q;

    // Advance the valid bits; on stall every bit holds, so no bubble collapse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : stg
        // Operand bits still unresolved when this stage is entered.
        localparam int RW = WIDTH - k*BLOCK;

        logic [RW-1:0]          a_in;
        logic [RW-1:0]          b_in;
        logic                   c_in;
        logic [BLOCK-1:0]       g;
        logic [BLOCK-1:0]       p;
        logic [BLOCK-1:0]       sl_s;
        logic [BLOCK:0]         cv;
        logic [(k+1)*BLOCK-1:0] s_d;
        logic [(k+1)*BLOCK-1:0] s_q;
        logic                   c_q;

        if (k == 0) begin : g_src
            assign a_in = src1;
            assign b_in = b_prep;
            assign c_in = cin_prep;
            assign s_d  = sl_s;
        end else begin : g_src
            assign a_in = stg[k-1].g_op.a_q;
            assign b_in = stg[k-1].g_op.b_q;
            assign c_in = stg[k-1].c_q;
            assign s_d  = {sl_s, stg[k-1].s_q};
        end

        // Slice lookahead: generate/propagate, carry chain seeded by the
        // carry from the previous stage, then the slice sum bits.
        always_comb begin
            g     = a_in[BLOCK-1:0] & b_in[BLOCK-1:0];
            p     = a_in[BLOCK-1:0] ^ b_in[BLOCK-1:0];
            cv    = '0;
            cv[0] = c_in;
            for (int i = 0; i < BLOCK; i++) begin
                cv[i+1] = g[i] | (p[i] & cv[i]);
            end
            sl_s  = p ^ cv[BLOCK-1:0];
        end

        // Register the accumulated sum bits and the slice carry-out.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else if (adv) begin
                s_q <= s_d;
                c_q <= cv[BLOCK];
            end
        end

        if (k < STAGES-1) begin : g_op
            logic [RW-BLOCK-1:0] a_q;
            logic [RW-BLOCK-1:0] b_q;

            // Forward only the operand bits later stages still need.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[RW-1:BLOCK];
                    b_q <= b_in[RW-1:BLOCK];
                end
            end
        end else begin : g_fl
            logic ovf_q;
            logic zero_q;

            // Top slice: flags are registered alongside the final sum.
            // cv[BLOCK-1] is the carry into the MSB.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    ovf_q  <= cv[BLOCK-1] ^ cv[BLOCK];
                    zero_q <= ~|s_d;
                end
            end
        end
    end

    assign sum       = stg[STAGES-1].s_q;
    assign carry_out = stg[STAGES-1].c_q;
    assign overflow  = stg[STAGES-1].g_fl.ovf_q;
    assign zero      = stg[STAGES-1].g_fl.zero_q;

endmodule
